// File: rtl/pcie_dma_pkg.sv
// Shared constants and FSM encoding for the PCIe DMA burst reader.
package pcie_dma_pkg;

    localparam int WORD_W         = 128;
    localparam int BYTES_PER_WORD = 16;
    localparam int OFFSET_W       = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_e;

    // Word offset to byte offset; the result is wide enough to never overflow.
    function automatic logic [OFFSET_W+3:0] word_to_byte(input logic [OFFSET_W-1:0] words);
        return (OFFSET_W + 4)'(words) * (OFFSET_W + 4)'(BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/pcie_skid_buf2.sv
// Two-entry valid/ready slice fed by a read port whose data lands one cycle after the read.
module pcie_skid_buf2
    import pcie_dma_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [WORD_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [WORD_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [1:0]        count_o
);

    logic [WORD_W-1:0] head_q, head_d;
    logic [WORD_W-1:0] tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic              pop;

    // An empty buffer passes arriving data straight through so a beat can leave the cycle it lands.
    assign out_valid_o = (count_q != 2'd0) || in_valid_i;
    assign out_data_o  = ((count_q == 2'd0) && in_valid_i) ? in_data_i : head_q;
    assign count_o     = count_q;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (in_valid_i && !out_ready_i) begin
                    head_d  = in_data_i;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (pop && in_valid_i) begin
                    head_d = in_data_i;
                end else if (pop) begin
                    count_d = 2'd0;
                end else if (in_valid_i) begin
                    tail_d  = in_data_i;
                    count_d = 2'd2;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    if (in_valid_i) begin
                        tail_d = in_data_i;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pcie_dma_burst_rd.sv
// Burst reader: waits for enough FIFO data, requests a PCIe DMA burst, then streams
// BURST_LEN words from the FIFO through a skid buffer, walking a frame buffer.
module pcie_dma_burst_rd
    import pcie_dma_pkg::*;
#(
    parameter int BURST_LEN = 32,
    parameter int DEPTH_W   = 12,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [23:0]       cfg_frame_words,
    output logic              fifo_rd_en,
    input  logic [WORD_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    input  logic [DEPTH_W:0]  fifo_rd_water_level,
    output logic              burst_req,
    output logic [ADDR_W-1:0] burst_addr,
    output logic [8:0]        burst_len,
    input  logic              burst_ack,
    output logic              dout_valid,
    output logic [WORD_W-1:0] dout_data,
    output logic              dout_last,
    input  logic              dout_ready,
    output logic              frame_done,
    output logic              busy
);

    localparam logic [8:0]         BURST_LEN_W = 9'(BURST_LEN);
    localparam logic [DEPTH_W:0]   BURST_LVL   = (DEPTH_W + 1)'(BURST_LEN);
    localparam logic [OFFSET_W:0]  BURST_STEP  = (OFFSET_W + 1)'(BURST_LEN);

    state_e              state_q, state_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [23:0]         frame_words_q, frame_words_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [8:0]          rd_cnt_q, rd_cnt_d;
    logic [8:0]          beat_cnt_q, beat_cnt_d;
    logic                inflight_q;
    logic                frame_done_q, frame_done_d;

    logic [1:0]          skid_count;
    logic                pop;
    logic [2:0]          occ_after;
    logic [OFFSET_W:0]   next_off;
    logic                wrap;

    pcie_skid_buf2 u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (inflight_q),
        .in_data_i   (fifo_rd_data),
        .out_valid_o (dout_valid),
        .out_data_o  (dout_data),
        .out_ready_i (dout_ready),
        .count_o     (skid_count)
    );

    assign pop = dout_valid && dout_ready;

    // Slots still taken once this cycle settles; a new read needs one free slot when it lands.
    assign occ_after  = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = (state_q == ST_XFER) && (rd_cnt_q != BURST_LEN_W)
                        && !fifo_rd_empty && (occ_after < 3'd2);

    assign dout_last  = dout_valid && (beat_cnt_q == BURST_LEN_W - 9'd1);
    assign burst_req  = (state_q == ST_REQ);
    assign burst_addr = addr_q;
    assign burst_len  = BURST_LEN_W;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);

    assign next_off = {1'b0, offset_q} + BURST_STEP;
    assign wrap     = (next_off >= {1'b0, frame_words_q});

    always_comb begin
        state_d       = state_q;
        offset_d      = offset_q;
        frame_words_d = frame_words_q;
        addr_d        = addr_q;
        rd_cnt_d      = rd_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        frame_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && (fifo_rd_water_level >= BURST_LVL)) begin
                    state_d       = ST_REQ;
                    frame_words_d = cfg_frame_words;
                    addr_d        = cfg_base_addr + ADDR_W'(word_to_byte(offset_q));
                end
            end
            ST_REQ: begin
                if (burst_ack) begin
                    state_d    = ST_XFER;
                    rd_cnt_d   = 9'd0;
                    beat_cnt_d = 9'd0;
                end
            end
            ST_XFER: begin
                if (fifo_rd_en) begin
                    rd_cnt_d = rd_cnt_q + 9'd1;
                end
                if (pop) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                end
                if (pop && dout_last) begin
                    state_d = ST_IDLE;
                    if (wrap) begin
                        offset_d     = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        offset_d = next_off[OFFSET_W-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            offset_q      <= '0;
            frame_words_q <= '0;
            addr_q        <= '0;
            rd_cnt_q      <= 9'd0;
            beat_cnt_q    <= 9'd0;
            inflight_q    <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            offset_q      <= offset_d;
            frame_words_q <= frame_words_d;
            addr_q        <= addr_d;
            rd_cnt_q      <= rd_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            inflight_q    <= fifo_rd_en;
            frame_done_q  <= frame_done_d;
        end
    end

endmodule

// File: doc/pcie_dma_burst_rd.md
PCIE_DMA_BURST_RD -- requirements
Module: pcie_dma_burst_rd

Interface
REQ-001 SHALL have parameter BURST_LEN, default 32, meaning 128-bit words per burst (legal 1..256).
REQ-002 SHALL have parameter DEPTH_W, default 12, meaning FIFO read address width; the level input is DEPTH_W+1 bits.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning PCIe byte address width.
REQ-004 SHALL have port clk  in  1  single clock, which is the FIFO read clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  in  1  enables new bursts.
REQ-007 SHALL have port cfg_base_addr  in  ADDR_W  frame buffer base byte address.
REQ-008 SHALL have port cfg_frame_words  in  24  frame size in words, a nonzero multiple of BURST_LEN.
REQ-009 SHALL have port fifo_rd_en  out  1  FIFO read enable.
REQ-010 SHALL have port fifo_rd_data  in  128  FIFO read data.
REQ-011 SHALL have port fifo_rd_empty  in  1  FIFO empty flag.
REQ-012 SHALL have port fifo_rd_water_level  in  DEPTH_W+1  FIFO read-side level.
REQ-013 SHALL have port burst_req  out  1  burst request to the DMA engine.
REQ-014 SHALL have port burst_addr  out  ADDR_W  burst start byte address.
REQ-015 SHALL have port burst_len  out  9  burst length in words, equal to BURST_LEN.
REQ-016 SHALL have port burst_ack  in  1  DMA accepts the request.
REQ-017 SHALL have port dout_valid  out  1  data beat valid.
REQ-018 SHALL have port dout_data  out  128  data beat.
REQ-019 SHALL have port dout_last  out  1  final beat of the burst.
REQ-020 SHALL have port dout_ready  in  1  DMA accepts the beat.
REQ-021 SHALL have ports frame_done  out  1  one-cycle pulse at frame wrap, and busy  out  1  high in any state other than IDLE.

Function
REQ-022 SHALL treat fifo_rd_data as valid exactly 1 cycle after a cycle with fifo_rd_en=1 (no output register in the FIFO).
REQ-023 SHALL implement a state machine with states IDLE, REQ and XFER.
REQ-024 In IDLE, the block SHALL go to REQ when en=1 and fifo_rd_water_level >= BURST_LEN.
REQ-025 In REQ, the block SHALL hold burst_req=1 and keep burst_addr = cfg_base_addr + offset*16 and burst_len stable until burst_ack=1, then go to XFER.
REQ-026 In XFER, the block SHALL read exactly BURST_LEN words and SHALL never assert fifo_rd_en while fifo_rd_empty=1.
REQ-027 The block SHALL buffer read data in a 2-entry skid buffer and SHALL assert fifo_rd_en only when (in-flight reads + buffered entries) < 2, or when the buffer is being drained in the same cycle.
REQ-028 While dout_valid=1 and dout_ready=0, dout_data and dout_last SHALL hold stable.
REQ-029 A beat SHALL transfer on dout_valid & dout_ready.
REQ-030 dout_last SHALL be 1 only on beat BURST_LEN.
REQ-031 With dout_ready=1 and the FIFO not empty, the block SHALL sustain 1 beat per cycle.
REQ-032 The first fifo_rd_en SHALL occur in the first XFER cycle, and the first dout_valid one cycle later.
REQ-033 When the last beat transfers, the block SHALL return to IDLE and update offset += BURST_LEN.
REQ-034 If offset + BURST_LEN >= cfg_frame_words, offset SHALL become 0 and frame_done SHALL pulse for 1 cycle.
REQ-035 offset SHALL be 24 bits; burst_addr SHALL be computed modulo 2^ADDR_W.
REQ-036 en SHALL be sampled only in IDLE; deasserting en mid-burst SHALL let the burst complete.
REQ-037 cfg_* inputs SHALL be sampled on entry to REQ.
REQ-038 If the FIFO goes empty mid-XFER, the block SHALL stall without losing or duplicating words.

Reset
REQ-039 On rst_n=0, asynchronously: state=IDLE, offset=0, skid buffer empty, and fifo_rd_en, burst_req, dout_valid, dout_last, frame_done, busy all =0; burst_addr=0 and dout_data=0.
REQ-040 Reset mid-burst SHALL abort the burst; words already read are discarded.

Structure
REQ-041 A shared package pcie_dma_pkg SHALL hold the state encoding, the word width 128 and the bytes-per-word constant 16.
REQ-042 The skid buffer SHALL be a sub-module pcie_skid_buf2 (2-entry valid/ready register slice with a 1-cycle-latency input).

Verification
REQ-043 BURST_LEN=32, level=40, en=1, ack after 3 cycles, ready=1 -> 32 beats on consecutive cycles in FIFO order, last beat with dout_last=1, 32 fifo_rd_en pulses total.
REQ-044 Level=31 -> burst_req stays 0; raising level to 32 -> burst_req=1 next cycle.
REQ-045 ready toggling 1/0 every cycle plus the FIFO going empty for 5 cycles mid-burst -> data stable while stalled, no lost or duplicate words, fifo_rd_en=0 while empty.
REQ-046 base=0x1000_0000, frame_words=64, 3 bursts -> burst_addr = 0x1000_0000, 0x1000_0200, then 0x1000_0000; frame_done pulses after burst 2.
REQ-047 rst_n low during beat 10 -> all outputs 0 immediately; the next burst starts at offset 0.
